// File: rtl/params_pkg.sv
// Shared parameters and types for the band-pass FIR output path.
package params_pkg;
  localparam int OUTPUT_WIDTH   = 16;
  localparam int FIFO_DEPTH     = 16;
  localparam int FIFO_AF_THRESH = 12;

  typedef logic signed [OUTPUT_WIDTH-1:0] out_t;
  typedef logic [$clog2(FIFO_DEPTH):0]    fifo_cnt_t;
endpackage

// File: rtl/bpf_drop_monitor.sv
// Sticky overflow flag and saturating drop counter for beats the FIFO could not absorb.
module bpf_drop_monitor #(
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              drop,
  input  logic              clr,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count
);
  // A drop in the same cycle as a clear wins: the drop is counted after the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr)                drop_count <= DROP_W'(1);
      else if (~&drop_count)  drop_count <= drop_count + DROP_W'(1);
    end else if (clr) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end
endmodule

// File: rtl/bpf_out_fifo.sv
// Elastic FWFT buffer behind the non-stallable FIR core; drops beats when full.
module bpf_out_fifo
  import params_pkg::*;
#(
  parameter int DATA_W    = OUTPUT_WIDTH,
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int AF_THRESH = FIFO_AF_THRESH,
  parameter int DROP_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_W-1:0]          m_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_count,
  input  logic                       clr_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              full, empty, pop, push, drop;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign s_ready     = !full;
  assign m_valid     = !empty;
  assign almost_full = (count >= CW'(AF_THRESH));
  assign m_data      = mem[rd_ptr];

  // A pop frees the slot in the same cycle, so a full FIFO still takes the beat.
  assign pop  = m_valid & m_ready;
  assign push = s_valid & (!full | pop);
  assign drop = s_valid & full & !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  bpf_drop_monitor #(.DROP_W(DROP_W)) u_drop_mon (
    .clk        (clk),
    .rst_n      (rst_n),
    .drop       (drop),
    .clr        (clr_overflow),
    .overflow   (overflow),
    .drop_count (drop_count)
  );
endmodule
